exe_div: RTL

- Multi-cycle divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the EXE stage and consumes the op1/op2/inst/reg_waddr bundle that ID delivers through id_exe.
- Holds the pipeline through ctrl with stallreq_o until the result is ready, then hands the result to the EXE write-back mux.
- Radix-2 restoring algorithm: one quotient bit per cycle.

---
 rtl/exe_div_if.sv | 28 ++
 rtl/exe_div.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_div_if.sv
// exe_div_if: request/response bundle between the EXE stage and the
// multi-cycle divide/remainder unit. The master drives the request
// side (start, cancel, operands); the slave is the divider itself.
interface exe_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic                  cancel_i;
    logic [2:0]            funct3_i;
    logic [DATA_WIDTH-1:0] op1_i;
    logic [DATA_WIDTH-1:0] op2_i;
    logic [4:0]            reg_waddr_i;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  valid_o;
    logic [4:0]            reg_waddr_o;
    logic                  busy_o;
    logic                  stallreq_o;

    modport master (
        output start_i, cancel_i, funct3_i, op1_i, op2_i, reg_waddr_i,
        input  result_o, valid_o, reg_waddr_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, cancel_i, funct3_i, op1_i, op2_i, reg_waddr_i,
        output result_o, valid_o, reg_waddr_o, busy_o, stallreq_o
    );
endinterface

// File: rtl/exe_div.sv
// exe_div: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; signed operations run on magnitudes and
// the signs are restored after the last iteration. Divide-by-zero and
// signed overflow finish in one cycle without iterating.
// Optional build macro DIV_EARLY_OUT_EN: when defined, a divisor whose
// magnitude exceeds the dividend's also finishes in one cycle
// (quotient 0, remainder = raw dividend).
module exe_div #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input logic       clk_i,
    input logic       rst_n_i,
    exe_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    // Two's-complement negation on the signed view of a word.
    function automatic logic [DATA_WIDTH-1:0] negate(input logic signed [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH-1:0] n;
        n = -v;
        return n;
    endfunction

    // Magnitude of an operand; unsigned operations pass through untouched.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                        input logic              is_signed);
        return (is_signed && v[DATA_WIDTH-1]) ? negate(v) : v;
    endfunction

    // Re-apply a recorded sign to an unsigned result.
    function automatic logic [DATA_WIDTH-1:0] sign_fix(input logic [DATA_WIDTH-1:0] v,
                                                       input logic              neg);
        return neg ? negate(v) : v;
    endfunction

    state_t                state_q, state_d;
    logic                  sel_rem_q;
    logic [4:0]            waddr_q;
    logic [DATA_WIDTH-1:0] dividend_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic [DATA_WIDTH-1:0] quot_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  quot_neg_q;
    logic                  rem_neg_q;
    logic [DATA_WIDTH-1:0] result_q;

    // funct3[2] is always set for the M-extension divide group and carries
    // no information for this unit.
    logic unused_funct3;
    assign unused_funct3 = bus.funct3_i[2];

    // Request decode, evaluated while IDLE.
    logic                  op_signed;
    logic                  sel_rem;
    logic [DATA_WIDTH-1:0] op1_mag;
    logic [DATA_WIDTH-1:0] op2_mag;
    logic                  div_zero;
    logic                  overflow;
    logic                  early_out;
    logic                  special;
    logic                  accept;
    logic [DATA_WIDTH-1:0] special_res;

    assign op_signed = ~bus.funct3_i[0];
    assign sel_rem   = bus.funct3_i[1];
    assign op1_mag   = magnitude(bus.op1_i, op_signed);
    assign op2_mag   = magnitude(bus.op2_i, op_signed);
    assign div_zero  = (bus.op2_i == ZERO);
    assign overflow  = op_signed && (bus.op1_i == MIN_NEG) && (bus.op2_i == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
    assign early_out = !div_zero && (op2_mag > op1_mag);
`else
    assign early_out = 1'b0;
`endif
    assign special   = div_zero || overflow || early_out;
    assign accept    = (state_q == IDLE) && bus.start_i && !bus.cancel_i;

    // Result of the one-cycle cases, chosen between quotient and remainder.
    always_comb begin
        special_res = ZERO;
        if (div_zero) begin
            special_res = sel_rem ? bus.op1_i : ALL_ONES;
        end else if (overflow) begin
            special_res = sel_rem ? ZERO : MIN_NEG;
        end else if (early_out) begin
            special_res = sel_rem ? bus.op1_i : ZERO;
        end
    end

    // One restoring step: shift in the next dividend bit, trial-subtract.
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quot_next;
    logic [DATA_WIDTH-1:0] quot_final;
    logic [DATA_WIDTH-1:0] rem_final;
    logic                  last_iter;

    assign shifted    = {rem_q, dividend_q[DATA_WIDTH-1]};
    assign trial      = shifted - {1'b0, divisor_q};
    assign q_bit      = ~trial[DATA_WIDTH];
    assign rem_next   = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign quot_next  = {quot_q[DATA_WIDTH-2:0], q_bit};
    assign quot_final = sign_fix(quot_next, quot_neg_q);
    assign rem_final  = sign_fix(rem_next, rem_neg_q);
    assign last_iter  = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: special cases skip CALC, cancel aborts IDLE/CALC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: latch the request, iterate, and capture the final result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_rem_q  <= 1'b0;
            waddr_q    <= 5'd0;
            dividend_q <= ZERO;
            divisor_q  <= ZERO;
            quot_q     <= ZERO;
            rem_q      <= ZERO;
            cnt_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= ZERO;
        end else begin
            if (accept) begin
                sel_rem_q  <= sel_rem;
                waddr_q    <= bus.reg_waddr_i;
                dividend_q <= op1_mag;
                divisor_q  <= op2_mag;
                quot_q     <= ZERO;
                rem_q      <= ZERO;
                cnt_q      <= '0;
                quot_neg_q <= op_signed && (bus.op1_i[DATA_WIDTH-1] ^ bus.op2_i[DATA_WIDTH-1]);
                rem_neg_q  <= op_signed && bus.op1_i[DATA_WIDTH-1];
                if (special) begin
                    result_q <= special_res;
                end
            end else if ((state_q == CALC) && !bus.cancel_i) begin
                dividend_q <= {dividend_q[DATA_WIDTH-2:0], 1'b0};
                cnt_q      <= cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    quot_q   <= quot_final;
                    rem_q    <= rem_final;
                    result_q <= sel_rem_q ? rem_final : quot_final;
                end else begin
                    quot_q <= quot_next;
                    rem_q  <= rem_next;
                end
            end
        end
    end

    assign bus.result_o    = result_q;
    assign bus.reg_waddr_o = waddr_q;
    assign bus.valid_o     = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.stallreq_o  = accept || (state_q == CALC);

endmodule
